// File: rtl/regfile_dumper_pkg.sv
// Shared constants and state encoding for the register-file dumper.
// Imported by the dump interface, the dumper and its bench.
package regfile_dumper_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 8;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_READ,
    DUMP_SEND,
    DUMP_SEND_CB,
    DUMP_DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready beat stream carrying {address, data} snapshots and the CB beat.
// The dumper drives the master side; the sink drives ready.
interface regfile_dumper_if;
  import regfile_dumper_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              cb;

  modport master (output valid, addr, data, cb, input ready);
  modport slave  (input valid, addr, data, cb, output ready);

endinterface

// File: rtl/regfile_dumper.sv
// Walks an inclusive register range on the regfile rt port and streams
// one snapshot beat per register, optionally followed by a CB beat.
module regfile_dumper
  import regfile_dumper_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    first_addr_i,
  input  logic [ADDR_W-1:0]    last_addr_i,
  input  logic                 include_cb_i,
  output logic [ADDR_W-1:0]    rt_addr_o,
  input  logic [DATA_W-1:0]    rt_data_i,
  input  logic                 cb_data_i,
  regfile_dumper_if.master     dump,
  output logic                 busy_o,
  output logic                 done_o
);

   dump_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cur_q;
   logic [ADDR_W-1:0] last_q;
   logic              inc_cb_q;
   logic [DATA_W-1:0] hold_q;
   logic              at_last;
   logic              xfer;

   assign at_last   = (cur_q == last_q);
   assign xfer      = dump.valid && dump.ready;
   assign rt_addr_o = cur_q;
   assign busy_o    = (state_q != DUMP_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_q <= DUMP_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d    = state_q;
      dump.valid = 1'b0;
      dump.addr  = '0;
      dump.data  = '0;
      dump.cb    = 1'b0;
      done_o     = 1'b0;
      unique case (state_q)
         DUMP_IDLE: if (start_i) state_d = DUMP_READ;
         DUMP_READ: state_d = DUMP_SEND;
         DUMP_SEND: begin
            dump.valid = 1'b1;
            dump.addr  = cur_q;
            dump.data  = hold_q;
            if (dump.ready) begin
               if (!at_last)      state_d = DUMP_READ;
               else if (inc_cb_q) state_d = DUMP_SEND_CB;
               else               state_d = DUMP_DONE;
            end
         end
         DUMP_SEND_CB: begin
            dump.valid = 1'b1;
            dump.data  = hold_q;
            dump.cb    = 1'b1;
            if (dump.ready) state_d = DUMP_DONE;
         end
         DUMP_DONE: begin
            done_o  = 1'b1;
            state_d = DUMP_IDLE;
         end
         default: state_d = DUMP_IDLE;
      endcase
   end

   // Range latch, walking address and the snapshot register behind each beat.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cur_q    <= '0;
         last_q   <= '0;
         inc_cb_q <= 1'b0;
         hold_q   <= '0;
      end else begin
         unique case (state_q)
            DUMP_IDLE: if (start_i) begin
               cur_q    <= first_addr_i;
               last_q   <= last_addr_i;
               inc_cb_q <= include_cb_i;
            end
            DUMP_READ: hold_q <= rt_data_i;
            DUMP_SEND: if (xfer) begin
               if (!at_last)      cur_q  <= cur_q + ADDR_W'(1);
               else if (inc_cb_q) hold_q <= {{(DATA_W-1){1'b0}}, cb_data_i};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a behavioural regfile feeds the rt port
// and each beat is compared against hand-computed {addr, data, cb} values.
module tb_regfile_dumper;
  import regfile_dumper_pkg::*;

  logic              clk = 1'b0;
  logic              reset_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] first_addr = '0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic              include_cb = 1'b0;
  logic              cb_data = 1'b0;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rt_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] regs [NUM_REGS];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int c0;

  regfile_dumper_if dump_bus ();

  assign rt_data = regs[rt_addr];

  regfile_dumper dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .first_addr_i (first_addr),
    .last_addr_i  (last_addr),
    .include_cb_i (include_cb),
    .rt_addr_o    (rt_addr),
    .rt_data_i    (rt_data),
    .cb_data_i    (cb_data),
    .dump         (dump_bus),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 32'(dump_bus.valid), 32'd0);
    check({tag, "_addr"},  32'(dump_bus.addr),  32'd0);
    check({tag, "_data"},  32'(dump_bus.data),  32'd0);
    check({tag, "_cb"},    32'(dump_bus.cb),    32'd0);
    check({tag, "_busy"},  32'(busy),           32'd0);
    check({tag, "_done"},  32'(done),           32'd0);
    check({tag, "_rt"},    32'(rt_addr),        32'd0);
  endtask

  // Called at a negedge; pulses start for one edge and checks launch latency.
  task automatic do_start(input logic [2:0] f, input logic [2:0] l, input logic inc);
    first_addr = f;
    last_addr  = l;
    include_cb = inc;
    start_i    = 1'b1;
    c0         = cyc;
    @(negedge clk);
    start_i = 1'b0;
    check("launch_busy",  32'(busy),           32'd1);
    check("launch_valid", 32'(dump_bus.valid), 32'd0);
  endtask

  // Waits (bounded) for the next valid beat and checks its payload.
  task automatic expect_beat(input string tag, input logic [2:0] a,
                             input logic [7:0] d, input logic c);
    int w = 0;
    @(negedge clk);
    while (!dump_bus.valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_seen"}, 32'(dump_bus.valid), 32'd1);
    check({tag, "_addr"}, 32'(dump_bus.addr),  32'(a));
    check({tag, "_data"}, 32'(dump_bus.data),  32'(d));
    check({tag, "_cb"},   32'(dump_bus.cb),    32'(c));
  endtask

  task automatic restore_regs();
    for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(8'h11 * (i + 1));
  endtask

  initial begin
    dump_bus.ready = 1'b0;
    restore_regs();
    cb_data = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset_i = 1'b1;
    @(negedge clk);

    // Full dump 0..7 plus CB with ready held high
    dump_bus.ready = 1'b1;
    do_start(3'd0, 3'd7, 1'b1);
    for (int i = 0; i < NUM_REGS; i++)
      expect_beat($sformatf("full_r%0d", i), 3'(i), DATA_W'(8'h11 * (i + 1)), 1'b0);
    expect_beat("full_cb", 3'd0, 8'h01, 1'b1);
    @(negedge clk);
    check("full_done",    32'(done),    32'd1);
    check("full_latency", 32'(cyc - c0), 32'd18);
    @(negedge clk);
    check("full_done_pulse", 32'(done), 32'd0);
    check("full_idle_busy",  32'(busy), 32'd0);

    // Wrap-around 6..1 without CB
    do_start(3'd6, 3'd1, 1'b0);
    expect_beat("wrap_6", 3'd6, 8'h77, 1'b0);
    expect_beat("wrap_7", 3'd7, 8'h88, 1'b0);
    expect_beat("wrap_0", 3'd0, 8'h11, 1'b0);
    expect_beat("wrap_1", 3'd1, 8'h22, 1'b0);
    @(negedge clk);
    check("wrap_done",  32'(done),           32'd1);
    check("wrap_no_cb", 32'(dump_bus.valid), 32'd0);
    @(negedge clk);
    check("wrap_rt_hold", 32'(rt_addr), 32'd1);

    // Backpressure on beat 2; r2 written after capture, r3 before capture
    do_start(3'd1, 3'd3, 1'b0);
    expect_beat("bp_1", 3'd1, 8'h22, 1'b0);
    @(negedge clk);
    dump_bus.ready = 1'b0;
    @(negedge clk);
    regs[2] = 8'hFF;
    regs[3] = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid%0d", i), 32'(dump_bus.valid), 32'd1);
      check($sformatf("bp_hold_addr%0d", i),  32'(dump_bus.addr),  32'd2);
      check($sformatf("bp_hold_data%0d", i),  32'(dump_bus.data),  32'h33);
      @(negedge clk);
    end
    dump_bus.ready = 1'b1;
    check("bp_2_data", 32'(dump_bus.data), 32'h33);
    expect_beat("bp_3", 3'd3, 8'hA5, 1'b0);
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    restore_regs();
    @(negedge clk);

    // Single register with a start pulse mid-dump
    do_start(3'd5, 3'd5, 1'b0);
    first_addr = 3'd0;
    last_addr  = 3'd7;
    include_cb = 1'b1;
    start_i    = 1'b1;
    expect_beat("single_5", 3'd5, 8'h66, 1'b0);
    start_i = 1'b0;
    @(negedge clk);
    check("single_done", 32'(done), 32'd1);
    @(negedge clk);
    check("single_idle_busy",  32'(busy),           32'd0);
    check("single_idle_valid", 32'(dump_bus.valid), 32'd0);

    // Reset mid-dump after three beats
    do_start(3'd0, 3'd7, 1'b1);
    expect_beat("abort_0", 3'd0, 8'h11, 1'b0);
    expect_beat("abort_1", 3'd1, 8'h22, 1'b0);
    expect_beat("abort_2", 3'd2, 8'h33, 1'b0);
    @(negedge clk);
    #2 reset_i = 1'b0;
    #1 check_idle_zero("abort");
    @(negedge clk);
    reset_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done%0d", i), 32'(done), 32'd0);
    end

    // Fresh dump after abort, CB now low
    cb_data = 1'b0;
    do_start(3'd2, 3'd3, 1'b1);
    expect_beat("after_2",  3'd2, 8'h33, 1'b0);
    expect_beat("after_3",  3'd3, 8'h44, 1'b0);
    expect_beat("after_cb", 3'd0, 8'h00, 1'b1);
    @(negedge clk);
    check("after_done", 32'(done), 32'd1);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Sequential reader for the 8 × 8-bit register file and its CB flag. On a start pulse it walks an inclusive address range on the regfile's rt read port, snapshots each register, and streams {address, data} beats over a valid/ready interface, optionally followed by one CB beat. It sits beside the regfile as the read-side counterpart to the write port, serving debug dump, state save, and bench checking without stalling the rs port.

## Interface
- NUM_REGS, 8, registers in the regfile
- ADDR_W, 3, register address width
- DATA_W, 8, register data width

- clk_i  in  1  clock, rising edge
- reset_i  in  1  reset; asynchronous assert, active-low (0 = reset)
- start_i  in  1  request a dump; sampled only in IDLE
- first_addr_i  in  ADDR_W  first register of range; latched on start
- last_addr_i  in  ADDR_W  last register of range (inclusive); latched on start
- include_cb_i  in  1  append CB beat after last register; latched on start
- rt_addr_o  out  ADDR_W  address driven to regfile rt read port
- rt_data_i  in  DATA_W  regfile rt read data (combinational from rt_addr_o)
- cb_data_i  in  1  regfile CB flag
- dump_valid_o  out  1  beat valid
- dump_ready_i  in  1  sink accepts beat
- dump_addr_o  out  ADDR_W  register address of beat (0 on CB beat)
- dump_data_o  out  DATA_W  register value, or {0…0, cb} on CB beat
- dump_cb_o  out  1  beat is the CB beat
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, READ, SEND, SEND_CB, DONE.
- IDLE: start_i=1 latches first/last/include_cb, cur ← first_addr_i, next state READ. Otherwise stay.
- READ: rt_addr_o = cur; at clock edge, hold ← rt_data_i; next state SEND.
- SEND: dump_valid_o=1, dump_addr_o=cur, dump_data_o=hold, dump_cb_o=0. On valid&ready: if cur==last → SEND_CB if include_cb latched, else DONE; otherwise cur ← cur+1 (mod NUM_REGS), next state READ.
- SEND_CB: cb sampled into hold at entry edge; dump_valid_o=1, dump_addr_o=0, dump_data_o={7'b0,cb}, dump_cb_o=1. On handshake → DONE.
- DONE: done_o=1 for one cycle, next state IDLE.
- Range wrap-around: last < first walks through 7 → 0. Beat count = ((last − first) mod 8) + 1. first==last yields one register beat.
- Payload is a snapshot. Regfile writes after capture do not change a pending beat. Regfile writes to a not-yet-read register are visible.
- start_i while busy_o=1 is ignored; there is no queueing.
- rt_addr_o holds cur in all states. Value in IDLE: last cur, 0 after reset.

## Timing
- Reset (reset_i=0, async): state IDLE; rt_addr_o, dump_valid_o, dump_addr_o, dump_data_o, dump_cb_o, busy_o, done_o all 0; latched range cleared. Reset mid-dump aborts with no done_o.
- Latency: start_i sampled at edge N; busy_o high after N; first dump_valid_o after edge N+1.
- Throughput: at most one beat per 2 cycles (READ + SEND) with dump_ready_i held high.
- Handshake: transfer on the edge where valid&ready=1. Once dump_valid_o is high, it stays high and all dump_* outputs stay stable until that transfer. Valid never depends combinationally on ready.
- done_o is asserted the cycle after the last transfer; busy_o falls with the return to IDLE.
- Full dump of 8 registers plus CB with ready held high: 18 cycles start→done_o.

## Structure
- Shared processor package: NUM_REGS, ADDR_W, DATA_W constants and the state enum (DUMP_IDLE, DUMP_READ, DUMP_SEND, DUMP_SEND_CB, DUMP_DONE).
- Single module, no sub-modules. Address increment uses natural ADDR_W-bit wrap.

## Test plan
- Preload r0..r7 = 8'h11..8'h88, CB=1; start first=0, last=7, include_cb=1, ready=1 → beats (0,11)…(7,88), then CB beat data=01 with dump_cb_o=1; done_o pulse.
- Wrap: first=6, last=1 → beats with addr 6,7,0,1 only; no CB beat; done_o after the 4th beat.
- Backpressure: ready=0 for 5 cycles while valid=1 → payload held. Regfile write of r2 ← 8'hFF during the stall leaves the pending beat (2,33) unchanged.
- Single register: first=last=5 → exactly one beat (5,66). start_i pulsed again mid-dump → ignored.
- Reset mid-dump after 3 beats → all outputs 0 immediately, no done_o. A new start afterward dumps correctly from first_addr_i.
- Reset values: hold reset_i=0 → every output 0 and busy_o=0.
